// File: rtl/coax_pkg.sv
// rtl/coax_pkg.sv - shared types and field layout for the coax receive controller
// Contents: controller state enum, FIFO entry layout {eof, err, data[9:0]},
// word-count width and an entry-packing helper.
package coax_pkg;

  localparam int DATA_W  = 10;
  localparam int ENTRY_W = 12;
  localparam int EOF_BIT = 11;
  localparam int ERR_BIT = 10;
  localparam int CNT_W   = 10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RECEIVE    = 2'd1,
    ST_DISCARD    = 2'd2,
    ST_ERROR_HOLD = 2'd3
  } state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic eof, input logic err,
                                                    input logic [DATA_W-1:0] data);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[EOF_BIT] = eof;
    e[ERR_BIT] = err;
    e[DATA_W-1:0] = data;
    return e;
  endfunction

endpackage

// File: rtl/coax_fifo.sv
// rtl/coax_fifo.sv - show-ahead synchronous FIFO for received coax entries
// Ports: clk, rst_n (async active-low), push/push_data (dropped when full),
// pop (ignored when empty), head (current head entry), full, empty.
module coax_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // One extra bit so that full and empty are distinguishable.
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/coax_rx_ctrl.sv
// rtl/coax_rx_ctrl.sv - coax receive controller: frames words into a FIFO with EOF/error markers
// Ports: clk, reset (async active-low), rx_data/rx_data_strobe/rx_active/rx_error
// from the receiver, rx_reset to the receiver, rd_data/rd_valid/rd_en FIFO read
// side, overflow (sticky) with overflow_clear.
// Optional: COAX_RX_CTRL_TIMEOUT_EN enables the idle-in-frame timeout.
module coax_rx_ctrl
  import coax_pkg::*;
#(
  parameter int DEPTH           = 64,
  parameter int RECOVERY_CLOCKS = 32,
  parameter int TIMEOUT_CLOCKS  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_data_strobe,
  input  logic               rx_active,
  input  logic               rx_error,
  output logic               rx_reset,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_en,
  output logic               overflow,
  input  logic               overflow_clear
);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   word_cnt;
  logic [15:0]        hold_cnt;
  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic               cnt_inc;
  logic               cnt_clr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               tmo_hit;
  logic               err_evt;
  logic               push_lost;

`ifdef COAX_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != ST_RECEIVE || rx_data_strobe) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CLOCKS-th consecutive strobe-free cycle in a frame.
  assign tmo_hit = (state == ST_RECEIVE) && !rx_data_strobe &&
                   (tmo_cnt == TW'(TIMEOUT_CLOCKS - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign err_evt = rx_error || tmo_hit;
  // Fullness is judged on start-of-cycle occupancy; a same-cycle pop never makes room.
  assign push_lost = push && fifo_full;

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_entry = '0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_active) begin
          state_nxt = ST_RECEIVE;
          cnt_clr   = 1'b1;
        end
      end
      ST_RECEIVE: begin
        // Error outranks end-of-frame, which outranks a data word.
        if (err_evt) begin
          push       = 1'b1;
          push_entry = make_entry(1'b1, 1'b1, word_cnt);
          state_nxt  = ST_ERROR_HOLD;
        end else if (!rx_active) begin
          push       = 1'b1;
          push_entry = make_entry(1'b1, 1'b0, word_cnt);
          state_nxt  = ST_IDLE;
        end else if (rx_data_strobe) begin
          push       = 1'b1;
          push_entry = make_entry(1'b0, 1'b0, rx_data);
          cnt_inc    = 1'b1;
        end
        if (push && fifo_full) state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (rx_error)       state_nxt = ST_ERROR_HOLD;
        else if (!rx_active) state_nxt = ST_IDLE;
      end
      ST_ERROR_HOLD: begin
        if (hold_cnt == 16'(RECOVERY_CLOCKS - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      hold_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;

      if (cnt_clr)                           word_cnt <= '0;
      else if (cnt_inc && word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;

      // Counts cycles already spent in ERROR_HOLD; zero on entry.
      if (state == ST_ERROR_HOLD && state_nxt == ST_ERROR_HOLD) hold_cnt <= hold_cnt + 1'b1;
      else                                                       hold_cnt <= '0;

      if (push_lost)           overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  // Receiver is held in reset while this block is in reset or recovering.
  assign rx_reset = !reset || (state == ST_ERROR_HOLD);
  assign rd_valid = !fifo_empty;

  coax_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_coax_rx_ctrl.sv
// tb/tb_coax_rx_ctrl.sv - self-checking bench for coax_rx_ctrl
module tb_coax_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int RC    = 32;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rx_data;
  logic        rx_data_strobe;
  logic        rx_active;
  logic        rx_error;
  logic        rx_reset;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        rd_en;
  logic        overflow;
  logic        overflow_clear;

  always #5 clk = ~clk;

  coax_rx_ctrl #(
    .DEPTH           (DEPTH),
    .RECOVERY_CLOCKS (RC),
    .TIMEOUT_CLOCKS  (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_data_strobe (rx_data_strobe),
    .rx_active      (rx_active),
    .rx_error       (rx_error),
    .rx_reset       (rx_reset),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_en          (rd_en),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: expected FIFO contents as a queue plus frame bookkeeping.
  logic [11:0] q[$];
  int mode;        // 0 idle, 1 in frame, 2 discarding, 3 holding receiver in reset
  int hold_left;
  int cnt;
  int idle_cyc;
  bit ovf;
  int pops;

  typedef struct {
    bit a; bit s; bit e; logic [9:0] d; bit r; bit c;
    bit ev; logic [11:0] ed; bit eo; bit er;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; hold_left = 0; cnt = 0; idle_cyc = 0; ovf = 0;
  endtask

  task automatic model_edge();
    bit full, pop, push, ovf_set, tmo;
    logic [11:0] ent;
    int nm;
    full = (q.size() == DEPTH);
    pop = rd_en && (q.size() > 0);
    push = 0; ovf_set = 0; tmo = 0; ent = '0; nm = mode;
    case (mode)
      0: if (rx_active) begin nm = 1; cnt = 0; idle_cyc = 0; end
      1: begin
`ifdef COAX_RX_CTRL_TIMEOUT_EN
        if (rx_data_strobe) idle_cyc = 0;
        else begin idle_cyc++; tmo = (idle_cyc >= TMO); end
`endif
        if (rx_error || tmo) begin push = 1; ent = {2'b11, 10'(cnt)}; nm = 3; hold_left = RC; end
        else if (!rx_active) begin push = 1; ent = {2'b10, 10'(cnt)}; nm = 0; end
        else if (rx_data_strobe) begin
          push = 1; ent = {2'b00, rx_data};
          if (cnt < 1023) cnt++;
        end
        if (push && full) begin push = 0; ovf_set = 1; nm = 2; end
      end
      2: if (rx_error) begin nm = 3; hold_left = RC; end
         else if (!rx_active) nm = 0;
      default: begin hold_left--; if (hold_left == 0) nm = 0; end
    endcase
    if (pop) begin void'(q.pop_front()); pops++; end
    if (push) q.push_back(ent);
    if (overflow_clear) ovf = 0;
    if (ovf_set) ovf = 1;
    mode = nm;
  endtask

  task automatic compare_model();
    chk("rd_valid", rd_valid, q.size() > 0);
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
    chk("overflow", overflow, ovf);
    chk("rx_reset", rx_reset, mode == 3);
  endtask

  task automatic step(input bit a, input bit s, input bit e, input logic [9:0] d,
                      input bit r, input bit c);
    @(negedge clk);
    rx_active = a; rx_data_strobe = s; rx_error = e; rx_data = d;
    rd_en = r; overflow_clear = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rd_valid || mode != 0); i++) step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [11:0] got[4];
    int n, k, p0;
    bit ra;

    reset = 0; rx_data = 0; rx_data_strobe = 0; rx_active = 0; rx_error = 0;
    rd_en = 0; overflow_clear = 0; pops = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rx_reset", rx_reset, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rel_rx_reset", rx_reset, 0);

    // Basic frame of three words, then read out.
    tv[0] = '{1,0,0,10'h000,0,0, 0,12'h000,0,0};
    tv[1] = '{1,1,0,10'h155,0,0, 1,12'h155,0,0};
    tv[2] = '{1,1,0,10'h2AA,0,0, 1,12'h155,0,0};
    tv[3] = '{1,1,0,10'h001,0,0, 1,12'h155,0,0};
    tv[4] = '{0,0,0,10'h000,0,0, 1,12'h155,0,0};
    tv[5] = '{0,0,0,10'h000,1,0, 1,12'h2AA,0,0};
    tv[6] = '{0,0,0,10'h000,1,0, 1,12'h001,0,0};
    tv[7] = '{0,0,0,10'h000,1,0, 1,12'h803,0,0};
    tv[8] = '{0,0,0,10'h000,1,0, 0,12'h000,0,0};
    for (int i = 0; i < 9; i++) begin
      step(tv[i].a, tv[i].s, tv[i].e, tv[i].d, tv[i].r, tv[i].c);
      chk($sformatf("vec%0d_valid", i), rd_valid, tv[i].ev);
      if (tv[i].ev) chk($sformatf("vec%0d_data", i), rd_data, tv[i].ed);
      chk($sformatf("vec%0d_ovf", i), overflow, tv[i].eo);
      chk($sformatf("vec%0d_rxr", i), rx_reset, tv[i].er);
    end

    // Error after two words: recovery length and error entry.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10'h0AA, 0, 0);
    step(1, 1, 0, 10'h0BB, 0, 0);
    step(1, 1, 1, 10'h3FF, 0, 0);
    n = 0; k = 0;
    while (rx_reset && n < 100) begin
      n++;
      if (rd_valid && k < 3) begin got[k] = rd_data; k++; end
      step(0, 0, 0, 0, 1, 0);
    end
    chk("hold_len", n, RC);
    chk("err_e0", got[0], 12'h0AA);
    chk("err_e1", got[1], 12'h0BB);
    chk("err_e2", got[2], 12'hC02);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 10'(i + 5), 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_err_head", rd_data, 12'h005);
    drain();

    // Overflow with DEPTH=4.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 10'(16 + i), 0, 0);
    chk("ovf_set", overflow, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ovf_clear", overflow, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10'h3C3, 0, 0);
    chk("ovf_next_frame", overflow, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      got[i] = rd_data;
      step(0, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_e%0d", i), got[i], 12'(16 + i));
    chk("ovf_no_eof", rd_valid, 0);
    step(0, 0, 0, 0, 0, 1);

    // Continuous reads, 10 words at one strobe per 16 clocks.
    p0 = pops;
    step(1, 0, 0, 0, 1, 0);
    for (int w = 0; w < 10; w++) begin
      repeat (15) step(1, 0, 0, 0, 1, 0);
      step(1, 1, 0, 10'(w * 37 + 1), 1, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("stream_pops", pops - p0, 11);
    chk("stream_empty", rd_valid, 0);

    // Reset in mid-frame.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 10'(i + 100), 0, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_rxr", rx_reset, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_valid_c", rd_valid, 0);
      chk("mid_rst_rxr_c", rx_reset, 1);
    end
    @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rel_rxr", rx_reset, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 10'h2C5, 0, 0);
    chk("mid_rel_word", rd_data, 12'h2C5);
    step(0, 0, 0, 0, 0, 0);
    drain();

    // Long idle inside a frame.
    step(1, 0, 0, 0, 0, 0);
    repeat (150) step(1, 0, 0, 0, 0, 0);
`ifdef COAX_RX_CTRL_TIMEOUT_EN
    chk("tmo_entry", rd_valid, 1);
    chk("tmo_data", rd_data, 12'hC00);
`else
    chk("tmo_none", rd_valid, 0);
`endif
    step(0, 0, 0, 0, 0, 0);
    drain();

    // Randomized traffic against the model.
    ra = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ra = !ra;
      step(ra, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
           10'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    drain();
    chk("final_empty", rd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coax_rx_ctrl.md
COAX_RX_CTRL -- requirements
Module: coax_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: FIFO entries, power of two, 4..1024.
REQ-002 SHALL have parameter RECOVERY_CLOCKS, default 32: cycles rx_reset is held after an error, 1..65535.
REQ-003 SHALL have parameter TIMEOUT_CLOCKS, default 1024: idle-in-frame limit, used only under REQ-030.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  10  received word from coax receiver, valid with rx_data_strobe.
REQ-007 rx_data_strobe  input  1  one-cycle pulse per received word.
REQ-008 rx_active  input  1  receiver is inside a frame.
REQ-009 rx_error  input  1  receiver error, level.
REQ-010 rx_reset  output  1  active-high reset to receiver.
REQ-011 rd_data  output  12  head entry {eof, err, data[9:0]}, show-ahead.
REQ-012 rd_valid  output  1  FIFO not empty.
REQ-013 rd_en  input  1  pop head entry.
REQ-014 overflow  output  1  sticky: frame data lost.
REQ-015 overflow_clear  input  1  clears overflow.

Function
REQ-016 SHALL implement states IDLE, RECEIVE, DISCARD, ERROR_HOLD.
REQ-017 IDLE: rx_reset=0; rx_active high -> RECEIVE with word count cleared.
REQ-018 RECEIVE: each rx_data_strobe pushes {0,0,rx_data} and increments 10-bit word count, saturating at 1023.
REQ-019 RECEIVE: rx_active falling with rx_error low pushes {1,0,count} -> IDLE.
REQ-020 RECEIVE: rx_error high (priority over strobe and falling rx_active in the same cycle) pushes {1,1,count} -> ERROR_HOLD; the strobed word that cycle is dropped.
REQ-021 Push while FIFO full (start-of-cycle occupancy; a same-cycle pop does not make room) SHALL drop the entry, set overflow, and go to DISCARD; this includes the EOF/error entry.
REQ-022 DISCARD: push nothing; rx_active low -> IDLE; rx_error high -> ERROR_HOLD.
REQ-023 ERROR_HOLD: rx_reset=1 for exactly RECOVERY_CLOCKS cycles, counted from entry, then IDLE; rx_active ignored while held.
REQ-024 Push-to-rd_valid latency SHALL be 1 cycle; rd_en with rd_valid=1 advances head next cycle; rd_en while empty ignored.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both take effect, occupancy unchanged.
REQ-026 overflow_clear same cycle as a new overflow: set wins.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy tracked with one extra bit.

Reset
REQ-028 While reset=0: state IDLE, FIFO empty, rd_valid=0, overflow=0, counters 0, rx_reset=1.
REQ-029 Reset mid-frame SHALL discard FIFO contents and partial frame; first cycle after release, rx_reset=0 and state IDLE; a frame in progress at release enters RECEIVE on that cycle (words from it are accepted).

Configuration
REQ-030 COAX_RX_CTRL_TIMEOUT_EN defined: in RECEIVE, a counter reset by every strobe reaching TIMEOUT_CLOCKS SHALL be treated as rx_error (REQ-020). Undefined: no counter, TIMEOUT_CLOCKS unused, RECEIVE waits indefinitely.

Structure
REQ-031 Package coax_pkg SHALL hold the state enum, entry field widths/positions (EOF bit 11, ERR bit 10), and count width.
REQ-032 FIFO SHALL be sub-module coax_fifo (parameter DEPTH, WIDTH=12, show-ahead, full/empty outputs); controller FSM in coax_rx_ctrl.

Verification
REQ-033 Frame of 3 words 0x155,0x2AA,0x001 then rx_active low -> entries {0,0,155},{0,0,2AA},{0,0,001},{1,0,003}; overflow=0.
REQ-034 rx_error after 2 words -> entries 2 data + {1,1,002}; rx_reset high exactly 32 cycles; next frame received normally.
REQ-035 DEPTH=4, frame of 6 words, no reads -> 4 data entries, overflow=1, no EOF entry; overflow_clear -> 0; next frame lost until reads free space.
REQ-036 Continuous reads during 10-word frame at 1 strobe/16 clk -> all 11 entries read in order, rd_valid never stuck.
REQ-037 reset low for 3 cycles after 5 words -> rd_valid=0, rx_reset=1 during, rx_reset=0 the cycle after release.
REQ-038 With COAX_RX_CTRL_TIMEOUT_EN, TIMEOUT_CLOCKS=100, strobes stop with rx_active high -> {1,1,count} at 100 cycles, ERROR_HOLD; without macro -> no entry.
